// File: rtl/bridge_dataslot_request_arbiter.sv
// Round-robin arbiter funnelling dataslot requests into one host command port.
// Optional WAIT timeout: define BRIDGE_DATASLOT_ARB_TIMEOUT_EN.
module bridge_dataslot_request_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ-1:0][15:0] req_slot_id,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [3:0]               req_status,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_write,
  output logic [15:0]              cmd_slot_id,
  input  logic                     rsp_valid,
  input  logic [3:0]               rsp_status,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] grant;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          pick_vld;
  logic [3:0]    status_q;
  logic          timeout;

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      TIMEOUT_CYCLES == 24'd0) begin : g_param_chk
    $error("bad arbiter parameters");
  end

`ifdef BRIDGE_DATASLOT_ARB_TIMEOUT_EN
  logic [23:0] wait_cnt;

  assign timeout = (wait_cnt == TIMEOUT_CYCLES - 24'd1);

  // Count cycles spent in WAIT; cleared whenever we leave it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 24'd1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Scan from last_grant+1 upward; the nearest active requester wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a real response beats a same-cycle timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nx = ISSUE;
      ISSUE:   if (cmd_ready) state_nx = WAIT;
      WAIT:    if (rsp_valid || timeout) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the granted command, the host status and the rr pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      cmd_write   <= 1'b0;
      cmd_slot_id <= '0;
      status_q    <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        grant       <= pick;
        cmd_write   <= req_write[pick];
        cmd_slot_id <= req_slot_id[pick];
      end
      if (state == WAIT) begin
        if (rsp_valid) begin
          status_q <= rsp_status;
        end else if (timeout) begin
          status_q <= 4'hF;
        end
      end
      if (state == RESP) begin
        last_grant <= grant;
      end
    end
  end

  assign cmd_valid  = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign req_done   = (state == RESP) ?
                      (NUM_REQ'(1) << grant) : '0;
  assign req_status = (state == RESP) ? status_q : 4'h0;

endmodule

// File: tb/tb_bridge_dataslot_request_arbiter.sv
// Directed bench for bridge_dataslot_request_arbiter.
// Scoreboards expected commands and completions.
module tb_bridge_dataslot_request_arbiter;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0]        req_write = '0;
  logic [N-1:0][15:0]  req_slot_id = '0;
  logic [N-1:0]        req_done;
  logic [3:0]          req_status;
  logic                cmd_valid;
  logic                cmd_ready = 1'b1;
  logic                cmd_write;
  logic [15:0]         cmd_slot_id;
  logic                rsp_valid;
  logic [3:0]          rsp_status;
  logic                busy;

  logic                host_rsp = 1'b0;
  logic                stray_rsp = 1'b0;
  logic                host_en = 1'b1;
  logic [3:0]          rsp_code = 4'h0;
  int                  rsp_delay = 0;

  int                  checks = 0;
  int                  errors = 0;
  int                  hs_count = 0;
  logic [16:0]         cmd_q[$];
  logic [7:0]          done_q[$];

  assign rsp_valid  = host_rsp | stray_rsp;
  assign rsp_status = stray_rsp ? 4'h7 : rsp_code;

  always #5 clk = ~clk;

  bridge_dataslot_request_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_slot_id (req_slot_id),
    .req_done    (req_done),
    .req_status  (req_status),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_slot_id (cmd_slot_id),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .busy        (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_done(input int idx,
                           input int budget,
                           output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (req_done[idx]) break;
    end
    chk("done_seen", 32'(req_done[idx]), 32'd1);
    step();
    req_valid[idx] = 1'b0;
  endtask

  task automatic count_done(input int want,
                            input int budget);
    int n;
    n = 0;
    for (int c = 0; c < budget && n < want; c++) begin
      @(negedge clk);
      if (req_done != '0) n++;
    end
    chk("done_count", n, want);
  endtask

  // Host model: accept commands, answer after rsp_delay cycles.
  initial forever begin
    @(negedge clk);
    if (cmd_valid && cmd_ready) begin
      hs_count++;
      if (cmd_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_cmd observed=%0h expected=none",
               {cmd_write, cmd_slot_id});
      end else begin
        chk("cmd", {15'd0, cmd_write, cmd_slot_id},
            {15'd0, cmd_q.pop_front()});
      end
      if (host_en) begin
        @(posedge clk);
        repeat (rsp_delay) @(posedge clk);
        #1 host_rsp = 1'b1;
        @(posedge clk);
        #1 host_rsp = 1'b0;
      end
    end
  end

  // Completion monitor.
  initial forever begin
    @(negedge clk);
    if (req_done != '0) begin
      checks++;
      assert (done_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done observed=%0h expected=none",
               {req_done, req_status});
      end
      if (done_q.size() != 0) begin
        checks--;
        chk("done", {24'd0, req_done, req_status},
            {24'd0, done_q.pop_front()});
      end
    end else begin
      chk("idle_status", 32'(req_status), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int hs0;

    // reset values
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_req_done", 32'(req_done), 32'd0);
    chk("rst_req_status", 32'(req_status), 32'd0);
    chk("rst_cmd_write", 32'(cmd_write), 32'd0);
    chk("rst_cmd_slot", 32'(cmd_slot_id), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // single write, minimum latency
    req_slot_id[0] = 16'h0005;
    req_write[0]   = 1'b1;
    cmd_q.push_back({1'b1, 16'h0005});
    done_q.push_back({4'b0001, 4'h0});
    req_valid[0] = 1'b1;
    wait_done(0, 20, cyc);
    chk("min_latency", cyc, 4);

    // all requesting: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_slot_id[i] = 16'h0100 + 16'(i);
      req_write[i]   = (i % 2 == 1);
    end
    for (int j = 0; j < 5; j++) begin
      cmd_q.push_back({j % 2 == 1, 16'h0100 + 16'(j % N)});
      done_q.push_back({4'(1 << (j % N)), 4'h0});
    end
    req_valid = '1;
    count_done(5, 100);
    step();
    req_valid = '0;

    // back-pressure: command held stable
    step();
    cmd_ready      = 1'b0;
    rsp_code       = 4'h3;
    req_slot_id[2] = 16'hBEEF;
    req_write[2]   = 1'b0;
    cmd_q.push_back({1'b0, 16'hBEEF});
    done_q.push_back({4'b0100, 4'h3});
    hs0 = hs_count;
    req_valid[2] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(cmd_valid), 32'd1);
      chk("hold_slot", 32'(cmd_slot_id), 32'hBEEF);
      chk("hold_write", 32'(cmd_write), 32'd0);
    end
    step();
    cmd_ready = 1'b1;
    wait_done(2, 20, cyc);
    chk("single_cmd", hs_count - hs0, 1);

    // stray response in IDLE, then early drop
    step();
    stray_rsp = 1'b1;
    step();
    stray_rsp = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_busy", 32'(busy), 32'd0);
    rsp_code       = 4'h0;
    req_slot_id[1] = 16'h1234;
    req_write[1]   = 1'b1;
    cmd_q.push_back({1'b1, 16'h1234});
    done_q.push_back({4'b0010, 4'h0});
    step();
    req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    wait_done(1, 20, cyc);

    // lone requester granted back-to-back
    rsp_code       = 4'h5;
    rsp_delay      = 2;
    req_slot_id[3] = 16'hA5A5;
    req_write[3]   = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cmd_q.push_back({1'b1, 16'hA5A5});
      done_q.push_back({4'b1000, 4'h5});
    end
    step();
    req_valid[3] = 1'b1;
    count_done(3, 60);
    step();
    req_valid[3] = 1'b0;
    rsp_delay = 0;
    rsp_code  = 4'h0;

    // host never answers
    host_en = 1'b0;
    step();
    req_slot_id[0] = 16'h0F0F;
    req_write[0]   = 1'b0;
`ifdef BRIDGE_DATASLOT_ARB_TIMEOUT_EN
    cmd_q.push_back({1'b0, 16'h0F0F});
    done_q.push_back({4'b0001, 4'hF});
    req_valid[0] = 1'b1;
    wait_done(0, 60, cyc);
    chk("timeout_latency", cyc, 19);
    step();
`endif
    cmd_q.push_back({1'b0, 16'h0F0F});
    req_valid[0] = 1'b1;
    repeat (12) @(negedge clk);
    chk("stuck_busy", 32'(busy), 32'd1);

    // reset in WAIT abandons the command
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(req_done), 32'd0);
    chk("abort_cmd_valid", 32'(cmd_valid), 32'd0);
    req_valid = '0;
    step();
    step();
    reset_n = 1'b1;
    host_en = 1'b1;
    step();

    // pointer restarts at index 0
    req_slot_id[0] = 16'h0001;
    req_write[0]   = 1'b0;
    req_slot_id[2] = 16'h0002;
    req_write[2]   = 1'b1;
    cmd_q.push_back({1'b0, 16'h0001});
    cmd_q.push_back({1'b1, 16'h0002});
    done_q.push_back({4'b0001, 4'h0});
    done_q.push_back({4'b0100, 4'h0});
    req_valid = 4'b0101;
    wait_done(0, 20, cyc);
    chk("post_rst_latency", cyc, 4);
    wait_done(2, 20, cyc);

    step();
    step();
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bridge_dataslot_request_arbiter.md
BRIDGE_DATASLOT_REQUEST_ARBITER -- requirements
Module: bridge_dataslot_request_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002: Parameter TIMEOUT_CYCLES, default 24'd10_000_000, WAIT-state cycle limit (24-bit).
REQ-003: clk  input  1  single clock for all logic.
REQ-004: reset_n  input  1  asynchronous, active-low reset.
REQ-005: req_valid  input  NUM_REQ  per-requester request, held until req_done.
REQ-006: req_write  input  NUM_REQ  per-requester opcode: 1 = dataslot request write, 0 = dataslot request read.
REQ-007: req_slot_id  input  NUM_REQ x 16  per-requester pocket::slot_id_t.
REQ-008: req_done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009: req_status  output  4  status accompanying req_done: 0 = ok, host code otherwise, 4'hF = timeout.
REQ-010: cmd_valid / cmd_ready  output / input  1 / 1  command handshake to the host command engine.
REQ-011: cmd_write  output  1  opcode of the issued command.
REQ-012: cmd_slot_id  output  16  slot id of the issued command.
REQ-013: rsp_valid  input  1  one-cycle host response strobe.
REQ-014: rsp_status  input  4  host response code.
REQ-015: busy  output  1  high in any state other than IDLE.

Function
REQ-016: The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017: In IDLE with any req_valid high, the block SHALL grant round-robin, starting at index (last_grant+1) mod NUM_REQ, latch opcode and slot id, and go to ISSUE next cycle.
REQ-018: In ISSUE, cmd_valid SHALL be high with stable cmd_write/cmd_slot_id; on cmd_valid&&cmd_ready go to WAIT.
REQ-019: In WAIT, on rsp_valid the block SHALL latch rsp_status and go to RESP; rsp_valid outside WAIT SHALL be ignored.
REQ-020: In RESP, req_done[grant] SHALL pulse for exactly one cycle with req_status, then return to IDLE; last_grant updates to grant.
REQ-021: Minimum latency req_valid to req_done SHALL be 4 cycles (cmd_ready and rsp_valid asserted immediately).
REQ-022: A requester dropping req_valid after grant SHALL NOT abort the command; its req_done still pulses.
REQ-023: Requests arriving during a transaction SHALL wait; no request is lost while req_valid stays high.
REQ-024: Round-robin pointer SHALL wrap from NUM_REQ-1 to 0; with one active requester it SHALL be granted back-to-back every transaction.
REQ-025: req_done and req_status SHALL be zero outside RESP.

Reset
REQ-026: On reset_n low, state SHALL be IDLE; cmd_valid, req_done, busy SHALL be 0; req_status, cmd_write, cmd_slot_id 0; last_grant NUM_REQ-1 (first grant index 0).
REQ-027: Reset asserted mid-transaction SHALL abandon it without a req_done pulse.

Configuration
REQ-028: With macro BRIDGE_DATASLOT_ARB_TIMEOUT_EN defined, a 24-bit counter SHALL count WAIT cycles; at TIMEOUT_CYCLES without rsp_valid go to RESP with req_status 4'hF; rsp_valid in the same cycle as timeout wins.
REQ-029: Without BRIDGE_DATASLOT_ARB_TIMEOUT_EN, WAIT SHALL persist until rsp_valid, with no counter logic.

Verification
REQ-030: req_valid=4'b0001, slot 16'h0005, write=1, cmd_ready=1, rsp 0 one cycle after WAIT -> cmd_slot_id 0x0005, cmd_write 1, req_done[0] at cycle 4, status 0.
REQ-031: req_valid=4'b1111 held -> grants issued in order 0,1,2,3,0.
REQ-032: cmd_ready low for 10 cycles -> cmd_valid, cmd_slot_id stable throughout; single command accepted.
REQ-033: rsp_status 4'h3 -> req_done on granted index only, req_status 4'h3; rsp_valid pulsed in IDLE -> no effect.
REQ-034: Macro defined, TIMEOUT_CYCLES=16, no rsp -> req_done after 16 WAIT cycles with status 4'hF; macro undefined -> busy remains high.
REQ-035: reset_n low during WAIT -> busy 0, no req_done; next request granted index 0.
